// File: rtl/serial_adder_pkg.sv
// Shared definitions for the bit-serial adder: state encodings and counter sizing.
package serial_adder_pkg;

  typedef logic [1:0] state_t;

  localparam state_t ST_IDLE  = 2'd0;
  localparam state_t ST_SHIFT = 2'd1;
  localparam state_t ST_DONE  = 2'd2;

  // Bit counter must hold 0..WIDTH without wrapping, and never collapse to zero bits.
  function automatic int cntWidth(input int width);
    return (width < 1) ? 1 : $clog2(width + 1);
  endfunction

endpackage

// File: rtl/serial_adder_fa.sv
// One-bit full adder cell used as the per-bit datapath stage of serial_adder.
module fa (
  input  logic a,
  input  logic b,
  input  logic cin,
  output logic sum,
  output logic cout
);

  assign sum  = a ^ b ^ cin;
  assign cout = (a & b) | (cin & (a ^ b));

endmodule

// File: rtl/serial_adder.sv
// Bit-serial WIDTH-bit adder: latches operands on start, adds one bit per clock LSB first,
// then presents a registered sum/cout together with a one-cycle done pulse.
module serial_adder
  import serial_adder_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] sum,
  output logic             cout
);

  localparam int             CW   = cntWidth(WIDTH);
  localparam logic [CW-1:0]  LAST = CW'(WIDTH - 1);

  state_t           r_state;
  logic [WIDTH-1:0] r_aSr;
  logic [WIDTH-1:0] r_bSr;
  logic             r_carry;
  logic [CW-1:0]    r_cnt;
  logic [WIDTH-1:0] r_sum;
  logic             r_cout;

  logic             w_sBit;
  logic             w_cNext;
  logic [WIDTH-1:0] w_sNext;
  logic             w_load;

  fa u_fa (
    .a    (r_aSr[0]),
    .b    (r_bSr[0]),
    .cin  (r_carry),
    .sum  (w_sBit),
    .cout (w_cNext)
  );

  // A new request is only accepted when no addition is in flight.
  assign w_load = start && ((r_state == ST_IDLE) || (r_state == ST_DONE));

  // Partial sum keeps only the WIDTH-1 bits already produced; the current bit completes it.
  generate
    if (WIDTH == 1) begin : g_oneBit
      assign w_sNext = w_sBit;
    end else begin : g_multiBit
      logic [WIDTH-2:0] r_sSr;

      assign w_sNext = {w_sBit, r_sSr};

      always_ff @(posedge clk) begin
        if (rst) begin
          r_sSr <= '0;
        end else if (w_load) begin
          r_sSr <= '0;
        end else if (r_state == ST_SHIFT) begin
          r_sSr <= w_sNext[WIDTH-1:1];
        end
      end
    end
  endgenerate

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= ST_IDLE;
      r_aSr   <= '0;
      r_bSr   <= '0;
      r_carry <= 1'b0;
      r_cnt   <= '0;
      r_sum   <= '0;
      r_cout  <= 1'b0;
    end else begin
      case (r_state)
        ST_SHIFT: begin
          r_aSr   <= r_aSr >> 1;
          r_bSr   <= r_bSr >> 1;
          r_carry <= w_cNext;
          r_cnt   <= r_cnt + CW'(1);
          if (r_cnt == LAST) begin
            r_sum   <= w_sNext;
            r_cout  <= w_cNext;
            r_state <= ST_DONE;
          end
        end
        ST_IDLE, ST_DONE: begin
          if (w_load) begin
            r_aSr   <= a;
            r_bSr   <= b;
            r_carry <= cin;
            r_cnt   <= '0;
            r_state <= ST_SHIFT;
          end else begin
            r_state <= ST_IDLE;
          end
        end
        default: begin
          r_state <= ST_IDLE;
        end
      endcase
    end
  end

  assign busy = (r_state == ST_SHIFT);
  assign done = (r_state == ST_DONE);
  assign sum  = r_sum;
  assign cout = r_cout;

endmodule

// File: tb/tb_serial_adder.sv
// Directed, table-driven bench for serial_adder at WIDTH=8 plus a WIDTH=1 instance.
module tb_serial_adder;

  typedef struct {
    logic [7:0] a;
    logic [7:0] b;
    logic       cin;
    logic [7:0] sum;
    logic       cout;
  } vec_t;

  logic       clk = 1'b0;
  logic       rst;
  logic       start8, cin8, busy8, done8, cout8;
  logic [7:0] a8, b8, sum8;
  logic       start1, cin1, busy1, done1, cout1;
  logic [0:0] a1, b1, sum1;

  int passed = 0;
  int total  = 0;

  vec_t vecs8[7];
  vec_t vecs1[8];

  serial_adder #(.WIDTH(8)) u_dut8 (
    .clk(clk), .rst(rst), .start(start8), .a(a8), .b(b8), .cin(cin8),
    .busy(busy8), .done(done8), .sum(sum8), .cout(cout8)
  );

  serial_adder #(.WIDTH(1)) u_dut1 (
    .clk(clk), .rst(rst), .start(start1), .a(a1), .b(b1), .cin(cin1),
    .busy(busy1), .done(done1), .sum(sum1), .cout(cout1)
  );

  always #5 clk = ~clk;

  task automatic checkOutput(input string name, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got === exp) passed++;
    else $display("[TB] FAIL %s: got %0h, expected %0h", name, got, exp);
  endtask

  // Presents one start pulse; returns at the falling edge after it was sampled.
  task automatic applyStimulus(input bit sel, input logic [7:0] av, input logic [7:0] bv,
                               input logic cv);
    @(negedge clk);
    if (sel) begin
      start1 = 1'b1; a1 = av[0]; b1 = bv[0]; cin1 = cv;
    end else begin
      start8 = 1'b1; a8 = av; b8 = bv; cin8 = cv;
    end
    @(negedge clk);
    start8 = 1'b0;
    start1 = 1'b0;
  endtask

  task automatic waitDone(input bit sel, output int busyCycles);
    bit found = 1'b0;
    int n = 0;
    busyCycles = 0;
    while (!found && n < 50) begin
      if (sel ? done1 : done8) begin
        found = 1'b1;
      end else begin
        if (sel ? busy1 : busy8) busyCycles++;
        @(negedge clk);
        n++;
      end
    end
    if (!found) checkOutput("done_timeout", 32'd0, 32'd1);
  endtask

  initial begin
    int bc;
    int cnt;
    int cyc;
    int t1;
    int t2;

    vecs8[0] = '{8'h3C, 8'h0F, 1'b0, 8'h4B, 1'b0};
    vecs8[1] = '{8'hFF, 8'h01, 1'b0, 8'h00, 1'b1};
    vecs8[2] = '{8'hFF, 8'hFF, 1'b1, 8'hFF, 1'b1};
    vecs8[3] = '{8'h00, 8'h00, 1'b0, 8'h00, 1'b0};
    vecs8[4] = '{8'h55, 8'hAA, 1'b1, 8'h00, 1'b1};
    vecs8[5] = '{8'h7F, 8'h01, 1'b0, 8'h80, 1'b0};
    vecs8[6] = '{8'h12, 8'h34, 1'b1, 8'h47, 1'b0};

    vecs1[0] = '{8'h0, 8'h0, 1'b0, 8'h0, 1'b0};
    vecs1[1] = '{8'h0, 8'h0, 1'b1, 8'h1, 1'b0};
    vecs1[2] = '{8'h0, 8'h1, 1'b0, 8'h1, 1'b0};
    vecs1[3] = '{8'h0, 8'h1, 1'b1, 8'h0, 1'b1};
    vecs1[4] = '{8'h1, 8'h0, 1'b0, 8'h1, 1'b0};
    vecs1[5] = '{8'h1, 8'h0, 1'b1, 8'h0, 1'b1};
    vecs1[6] = '{8'h1, 8'h1, 1'b0, 8'h0, 1'b1};
    vecs1[7] = '{8'h1, 8'h1, 1'b1, 8'h1, 1'b1};

    rst = 1'b1;
    start8 = 1'b0; a8 = '0; b8 = '0; cin8 = 1'b0;
    start1 = 1'b0; a1 = '0; b1 = '0; cin1 = 1'b0;
    repeat (2) @(negedge clk);
    checkOutput("rst_busy8", 32'(busy8), 32'd0);
    checkOutput("rst_done8", 32'(done8), 32'd0);
    checkOutput("rst_sum8",  32'(sum8),  32'd0);
    checkOutput("rst_cout8", 32'(cout8), 32'd0);
    checkOutput("rst_busy1", 32'(busy1), 32'd0);
    checkOutput("rst_done1", 32'(done1), 32'd0);
    checkOutput("rst_sum1",  32'(sum1),  32'd0);
    checkOutput("rst_cout1", 32'(cout1), 32'd0);
    rst = 1'b0;

    for (int i = 0; i < 7; i++) begin
      applyStimulus(1'b0, vecs8[i].a, vecs8[i].b, vecs8[i].cin);
      waitDone(1'b0, bc);
      checkOutput($sformatf("v%0d_sum", i),  32'(sum8),  32'(vecs8[i].sum));
      checkOutput($sformatf("v%0d_cout", i), 32'(cout8), 32'(vecs8[i].cout));
      checkOutput($sformatf("v%0d_busy_cycles", i), 32'(bc), 32'd8);
      @(negedge clk);
      checkOutput($sformatf("v%0d_done_width", i), 32'(done8), 32'd0);
    end

    // start while busy must be ignored; result must stay held during the new operation
    applyStimulus(1'b0, 8'h01, 8'h01, 1'b0);
    checkOutput("ign_sum_held", 32'(sum8), 32'h47);
    @(negedge clk);
    start8 = 1'b1; a8 = 8'h80; b8 = 8'h00;
    @(negedge clk);
    start8 = 1'b0;
    cnt = 0;
    for (int i = 0; i < 14; i++) begin
      if (done8) cnt++;
      @(negedge clk);
    end
    checkOutput("ign_done_count", 32'(cnt), 32'd1);
    checkOutput("ign_sum", 32'(sum8), 32'h02);
    checkOutput("ign_cout", 32'(cout8), 32'd0);

    // reset in the middle of SHIFT
    applyStimulus(1'b0, 8'h0F, 8'h0F, 1'b0);
    repeat (3) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    checkOutput("mid_rst_busy", 32'(busy8), 32'd0);
    checkOutput("mid_rst_done", 32'(done8), 32'd0);
    checkOutput("mid_rst_sum",  32'(sum8),  32'd0);
    checkOutput("mid_rst_cout", 32'(cout8), 32'd0);
    rst = 1'b0;
    cnt = 0;
    for (int i = 0; i < 14; i++) begin
      @(negedge clk);
      if (done8) cnt++;
    end
    checkOutput("mid_rst_no_done", 32'(cnt), 32'd0);

    // start held high through DONE: second operation follows immediately
    @(negedge clk);
    start8 = 1'b1; a8 = 8'h01; b8 = 8'h02; cin8 = 1'b0;
    @(negedge clk);
    a8 = 8'h10; b8 = 8'h20;
    cyc = 0; t1 = -1; t2 = -1;
    while (t2 < 0 && cyc < 40) begin
      @(negedge clk);
      cyc++;
      if (t1 >= 0 && cyc == t1 + 1) start8 = 1'b0;
      if (done8) begin
        if (t1 < 0) begin
          t1 = cyc;
          checkOutput("b2b_sum1", 32'(sum8), 32'h03);
        end else begin
          t2 = cyc;
          checkOutput("b2b_sum2", 32'(sum8), 32'h30);
          checkOutput("b2b_cout2", 32'(cout8), 32'd0);
        end
      end
    end
    start8 = 1'b0;
    checkOutput("b2b_gap", 32'(t2 - t1), 32'd9);

    for (int i = 0; i < 8; i++) begin
      applyStimulus(1'b1, vecs1[i].a, vecs1[i].b, vecs1[i].cin);
      waitDone(1'b1, bc);
      checkOutput($sformatf("w1_%0d_sum", i),  32'(sum1),  32'(vecs1[i].sum));
      checkOutput($sformatf("w1_%0d_cout", i), 32'(cout1), 32'(vecs1[i].cout));
      checkOutput($sformatf("w1_%0d_busy_cycles", i), 32'(bc), 32'd1);
    end

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
